// File: rtl/ram_block_cache_if.sv
// Request/response bundle for ram_block_cache: element port A, masked block port B,
// and the clear-engine handshake.
interface ram_block_cache_if #(
  parameter int ELEMENT_WIDTH      = 32,
  parameter int ELEMENTS_PER_BLOCK = 4,
  parameter int LG_EPB             = 2,
  parameter int LG_DEPTH           = 6
);
  logic                                      clear_req;
  logic                                      busy;

  logic                                      a_en;
  logic                                      a_we;
  logic [LG_DEPTH+LG_EPB-1:0]                a_addr;
  logic [ELEMENT_WIDTH-1:0]                  a_din;
  logic [ELEMENT_WIDTH-1:0]                  a_dout;
  logic                                      a_valid;

  logic                                      b_en;
  logic                                      b_we;
  logic [LG_DEPTH-1:0]                       b_addr;
  logic [ELEMENTS_PER_BLOCK-1:0]             b_mask;
  logic [ELEMENT_WIDTH*ELEMENTS_PER_BLOCK-1:0] b_din;
  logic [ELEMENT_WIDTH*ELEMENTS_PER_BLOCK-1:0] b_dout;
  logic                                      b_valid;

  modport master (
    output clear_req, a_en, a_we, a_addr, a_din, b_en, b_we, b_addr, b_mask, b_din,
    input  busy, a_dout, a_valid, b_dout, b_valid
  );

  modport slave (
    input  clear_req, a_en, a_we, a_addr, a_din, b_en, b_we, b_addr, b_mask, b_din,
    output busy, a_dout, a_valid, b_dout, b_valid
  );
endinterface

// File: rtl/ram_block_cache.sv
// Dual-port block cache RAM: element-wide port A, masked block-wide port B, both read-first,
// with a zero-fill engine that sweeps one block per cycle after reset or on clear_req.
module ram_block_cache #(
  parameter int ELEMENT_WIDTH      = 32,
  parameter int ELEMENTS_PER_BLOCK = 4,
  parameter int LG_EPB             = 2,
  parameter int DEPTH_BLOCKS       = 64,
  parameter int LG_DEPTH           = 6,
  parameter bit CLEAR_ON_RESET     = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  ram_block_cache_if.slave bus
);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;
  typedef logic [ELEMENT_WIDTH-1:0] elem_t;

  localparam state_t              RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
  localparam logic [LG_DEPTH-1:0] LAST_BLK  = LG_DEPTH'(DEPTH_BLOCKS - 1);

  elem_t mem [DEPTH_BLOCKS][ELEMENTS_PER_BLOCK];

  state_t                                      state_q, state_d;
  logic [LG_DEPTH-1:0]                         clr_cnt_q;
  logic                                        idle, clr_we, a_acc, b_acc;
  logic [LG_DEPTH-1:0]                         a_blk;
  logic [LG_EPB-1:0]                           a_el;

  elem_t                                       a_dout_p1;
  logic [ELEMENT_WIDTH*ELEMENTS_PER_BLOCK-1:0] b_dout_p1;
  logic                                        a_vld_p1, b_vld_p1;

  assign idle   = (state_q == S_IDLE);
  // Gate with rst_n so a held reset never scribbles over block 0.
  assign clr_we = (state_q == S_CLEAR) && rst_n;
  assign a_acc  = bus.a_en && idle;
  assign b_acc  = bus.b_en && idle;
  assign a_blk  = bus.a_addr[LG_DEPTH+LG_EPB-1 -: LG_DEPTH];
  assign a_el   = bus.a_addr[LG_EPB-1:0];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.clear_req) state_d = S_CLEAR;
      S_CLEAR: if (clr_cnt_q == LAST_BLK) state_d = S_IDLE;
      default: state_d = RST_STATE;
    endcase
  end

  // Stage p0 -> p1: control state, read-first output capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RST_STATE;
      clr_cnt_q <= '0;
      a_dout_p1 <= '0;
      b_dout_p1 <= '0;
      a_vld_p1  <= 1'b0;
      b_vld_p1  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_vld_p1 <= a_acc;
      b_vld_p1 <= b_acc;
      if (state_q == S_CLEAR) clr_cnt_q <= clr_cnt_q + 1'b1;
      if (a_acc) a_dout_p1 <= mem[a_blk][a_el];
      if (b_acc) begin
        for (int e = 0; e < ELEMENTS_PER_BLOCK; e++)
          b_dout_p1[e*ELEMENT_WIDTH +: ELEMENT_WIDTH] <= mem[bus.b_addr][LG_EPB'(e)];
      end
    end
  end

  // Array write port; port B is assigned last so it wins a same-element collision.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      for (int e = 0; e < ELEMENTS_PER_BLOCK; e++)
        mem[clr_cnt_q][LG_EPB'(e)] <= '0;
    end else begin
      if (a_acc && bus.a_we) mem[a_blk][a_el] <= bus.a_din;
      if (b_acc && bus.b_we) begin
        for (int e = 0; e < ELEMENTS_PER_BLOCK; e++)
          if (bus.b_mask[LG_EPB'(e)])
            mem[bus.b_addr][LG_EPB'(e)] <= bus.b_din[e*ELEMENT_WIDTH +: ELEMENT_WIDTH];
      end
    end
  end

  assign bus.busy    = (state_q == S_CLEAR);
  assign bus.a_dout  = a_dout_p1;
  assign bus.b_dout  = b_dout_p1;
  assign bus.a_valid = a_vld_p1;
  assign bus.b_valid = b_vld_p1;

endmodule

// File: tb/tb_ram_block_cache.sv
// Bench for ram_block_cache: vector table for port traffic, hand sequences for clear and reset,
// and a scoreboard that matches each valid output against its queued expectation and cycle.
module tb_ram_block_cache;
  localparam int EW = 32, EPB = 4, LGE = 2, DB = 64, LGD = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_block_cache_if #(.ELEMENT_WIDTH(EW), .ELEMENTS_PER_BLOCK(EPB), .LG_EPB(LGE), .LG_DEPTH(LGD)) bus();

  ram_block_cache #(.ELEMENT_WIDTH(EW), .ELEMENTS_PER_BLOCK(EPB), .LG_EPB(LGE),
                    .DEPTH_BLOCKS(DB), .LG_DEPTH(LGD), .CLEAR_ON_RESET(1'b1))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    string        name;
    logic [127:0] exp;
    int           cyc;
  } exp_t;

  typedef struct {
    logic         a_en, a_we;
    logic [7:0]   a_addr;
    logic [31:0]  a_din, exp_a;
    logic         b_en, b_we;
    logic [5:0]   b_addr;
    logic [3:0]   b_mask;
    logic [127:0] b_din, exp_b;
  } vec_t;

  exp_t aq[$];
  exp_t bq[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  vec_t v[16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] blk(input logic [31:0] e3, e2, e1, e0);
    return {e3, e2, e1, e0};
  endfunction

  function automatic vec_t mk(input logic ae, aw, input logic [7:0] aa, input logic [31:0] ad, ea,
                              input logic be, bw, input logic [5:0] ba, input logic [3:0] bm,
                              input logic [127:0] bd, eb);
    vec_t r;
    r.a_en = ae; r.a_we = aw; r.a_addr = aa; r.a_din = ad; r.exp_a = ea;
    r.b_en = be; r.b_we = bw; r.b_addr = ba; r.b_mask = bm; r.b_din = bd; r.exp_b = eb;
    return r;
  endfunction

  task automatic idle_inputs();
    bus.a_en = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_din = '0;
    bus.b_en = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_mask = '0; bus.b_din = '0;
  endtask

  // Called just after a falling edge; drives one cycle of traffic and queues expectations.
  task automatic step(input vec_t x, input string tag);
    exp_t e;
    bus.a_en = x.a_en; bus.a_we = x.a_we; bus.a_addr = x.a_addr; bus.a_din = x.a_din;
    bus.b_en = x.b_en; bus.b_we = x.b_we; bus.b_addr = x.b_addr; bus.b_mask = x.b_mask;
    bus.b_din = x.b_din;
    if (x.a_en) begin
      e.name = {tag, "_a"}; e.exp = {96'b0, x.exp_a}; e.cyc = cyc + 1;
      aq.push_back(e);
    end
    if (x.b_en) begin
      e.name = {tag, "_b"}; e.exp = x.exp_b; e.cyc = cyc + 1;
      bq.push_back(e);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic b_read(input logic [5:0] b, input logic [127:0] exp, input string tag);
    step(mk(0, 0, 0, 0, 0, 1, 0, b, 0, 0, exp), tag);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.a_valid) begin
      if (aq.size() == 0) chk("a_valid_unexpected", 1, 0);
      else begin
        e = aq.pop_front();
        chk(e.name, {96'b0, bus.a_dout}, e.exp);
        chk({e.name, "_latency"}, cyc, e.cyc);
      end
    end
    if (bus.b_valid) begin
      if (bq.size() == 0) chk("b_valid_unexpected", 1, 0);
      else begin
        e = bq.pop_front();
        chk(e.name, bus.b_dout, e.exp);
        chk({e.name, "_latency"}, cyc, e.cyc);
      end
    end
  end

  initial begin
    int n;
    v[0]  = mk(0, 0, 0, 0, 0, 1, 1, 6'd5, 4'hF, blk(32'hD, 32'hC, 32'hB, 32'hA), 0);
    v[1]  = mk(1, 0, {6'd5, 2'd2}, 0, 32'hC, 0, 0, 0, 0, 0, 0);
    v[2]  = mk(1, 1, {6'd5, 2'd1}, 32'h77, 32'hB, 0, 0, 0, 0, 0, 0);
    v[3]  = mk(0, 0, 0, 0, 0, 1, 0, 6'd5, 0, 0, blk(32'hD, 32'hC, 32'h77, 32'hA));
    v[4]  = mk(0, 0, 0, 0, 0, 1, 1, 6'd9, 4'hF, blk(1, 2, 3, 4), 0);
    v[5]  = mk(0, 0, 0, 0, 0, 1, 1, 6'd9, 4'b0101, blk(9, 9, 9, 9), blk(1, 2, 3, 4));
    v[6]  = mk(1, 0, {6'd9, 2'd2}, 0, 32'h9, 1, 0, 6'd9, 0, 0, blk(1, 9, 3, 9));
    v[7]  = mk(1, 1, {6'd7, 2'd0}, 32'h11, 0, 1, 1, 6'd7, 4'b0001, blk(0, 0, 0, 32'h22), 0);
    v[8]  = mk(1, 0, {6'd7, 2'd0}, 0, 32'h22, 1, 0, 6'd7, 0, 0, blk(0, 0, 0, 32'h22));
    v[9]  = mk(1, 1, {6'd7, 2'd0}, 32'h11, 32'h22, 1, 1, 6'd7, 4'b0010,
               blk(0, 0, 32'h33, 32'h22), blk(0, 0, 0, 32'h22));
    v[10] = mk(0, 0, 0, 0, 0, 1, 0, 6'd7, 0, 0, blk(0, 0, 32'h33, 32'h11));
    v[11] = mk(1, 1, {6'd7, 2'd3}, 32'h55, 0, 1, 1, 6'd7, 4'b0100,
               blk(32'hAA, 32'h66, 32'hAA, 32'hAA), blk(0, 0, 32'h33, 32'h11));
    v[12] = mk(1, 0, {6'd7, 2'd2}, 0, 32'h66, 1, 0, 6'd7, 0, 0, blk(32'h55, 32'h66, 32'h33, 32'h11));
    v[13] = mk(0, 0, 0, 0, 0, 1, 1, 6'd7, 4'b0000, {128{1'b1}}, blk(32'h55, 32'h66, 32'h33, 32'h11));
    v[14] = mk(0, 0, 0, 0, 0, 1, 0, 6'd7, 0, 0, blk(32'h55, 32'h66, 32'h33, 32'h11));
    v[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    idle_inputs();
    bus.clear_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 1);
    chk("rst_a_valid", bus.a_valid, 0);
    chk("rst_b_valid", bus.b_valid, 0);
    chk("rst_a_dout", bus.a_dout, 0);
    chk("rst_b_dout", bus.b_dout, 0);

    rst_n = 1'b1;
    n = 0;
    while (bus.busy && n < 200) begin n++; @(negedge clk); end
    chk("busy_cycles_after_reset", n, 64);
    b_read(6'd0, 0, "init_blk0");
    b_read(6'd31, 0, "init_blk31");
    b_read(6'd63, 0, "init_blk63");

    for (int i = 0; i < 16; i++) step(v[i], $sformatf("row%0d", i));
    repeat (2) @(negedge clk);
    chk("a_dout_hold", bus.a_dout, 32'h66);
    chk("b_dout_hold", bus.b_dout, blk(32'h55, 32'h66, 32'h33, 32'h11));

    // Clear request with a repeated request and ignored traffic mid-sweep.
    bus.clear_req = 1'b1;
    @(negedge clk);
    bus.clear_req = 1'b0;
    n = 0;
    while (bus.busy && n < 200) begin
      if (n == 30) bus.clear_req = 1'b1;
      if (n == 31) bus.clear_req = 1'b0;
      if (n == 60) begin
        bus.a_en = 1'b1; bus.a_we = 1'b1; bus.a_addr = {6'd5, 2'd1}; bus.a_din = 32'hFF;
        bus.b_en = 1'b1; bus.b_we = 1'b1; bus.b_addr = 6'd9; bus.b_mask = 4'hF;
        bus.b_din = {128{1'b1}};
      end
      if (n == 61) idle_inputs();
      n++;
      @(negedge clk);
    end
    chk("busy_cycles_clear_req", n, 64);
    chk("a_dout_hold_busy", bus.a_dout, 32'h66);
    b_read(6'd5, 0, "clr_blk5");
    b_read(6'd7, 0, "clr_blk7");
    b_read(6'd9, 0, "clr_blk9");
    step(mk(1, 0, {6'd5, 2'd1}, 0, 0, 0, 0, 0, 0, 0, 0), "clr_elem5_1");

    // Make both douts nonzero, then reset in the middle of a clear.
    step(mk(0, 0, 0, 0, 0, 1, 1, 6'd3, 4'hF, blk(1, 2, 3, 4), 0), "pre_rst_wr");
    step(mk(1, 0, {6'd3, 2'd0}, 0, 32'h4, 1, 0, 6'd3, 0, 0, blk(1, 2, 3, 4)), "pre_rst_rd");
    @(negedge clk);
    bus.clear_req = 1'b1;
    @(negedge clk);
    bus.clear_req = 1'b0;
    n = 0;
    while (bus.busy && n < 20) begin n++; @(negedge clk); end
    chk("busy_before_abort", n, 20);
    rst_n = 1'b0;
    #1;
    chk("abort_a_dout", bus.a_dout, 0);
    chk("abort_b_dout", bus.b_dout, 0);
    chk("abort_busy", bus.busy, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (bus.busy && n < 200) begin n++; @(negedge clk); end
    chk("busy_cycles_after_abort", n, 64);
    b_read(6'd3, 0, "abort_blk3");
    b_read(6'd63, 0, "abort_blk63");

    repeat (3) @(negedge clk);
    chk("a_queue_drained", aq.size(), 0);
    chk("b_queue_drained", bq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000");
    $fatal(1);
  end
endmodule
